// File: rtl/riscv_pkg.sv
// Shared types and constants for the writeback stage: result sources, load
// funct3 encodings and writeback FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'b00,
    WB_WAIT_MEM = 2'b01,
    WB_DRAIN    = 2'b10
  } wb_state_t;

  // Reserved result-source encoding falls back to the ALU result.
  function automatic logic [XLEN-1:0] select_result(input logic [1:0]      src,
                                                    input logic [XLEN-1:0] alu,
                                                    input logic [XLEN-1:0] pc4);
    if (src == RES_PC4) select_result = pc4;
    else                select_result = alu;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment: picks the byte/half lane out of an aligned word,
// sign- or zero-extends it, and flags accesses that cross their natural alignment.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            misaligned_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = 8'(word_i >> {addr_i, 3'b000});
    half_s = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o       = word_i;
    misaligned_o = 1'b0;
    unique case (funct3_i)
      F3_LB:  data_o = XLEN'(byte_s);
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH: begin
        data_o       = XLEN'(half_s);
        misaligned_o = addr_i[0];
      end
      F3_LHU: begin
        data_o       = {{(XLEN-16){1'b0}}, half_s};
        misaligned_o = addr_i[0];
      end
      F3_LW:  misaligned_o = (addr_i != 2'b00);
      // Unsupported load encodings pass the raw word without raising an error.
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage feeding the register file write port (WE3/AD3/WD3);
// holds the pipe while a load waits on data memory and counts retirements.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_reg_write,
  input  logic [ADDRESS_WIDTH-1:0] in_rd,
  input  logic [1:0]               in_result_src,
  input  logic [2:0]               in_funct3,
  input  logic [DATA_WIDTH-1:0]    in_alu_result,
  input  logic [DATA_WIDTH-1:0]    in_pc_plus4,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     flush,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     misalign_err,
  output logic [31:0]              instret
);

  wb_state_t                state_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [2:0]               funct3_q;
  logic [1:0]               addr_q;
  logic                     reg_write_q;
  logic                     misal_q;

  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] ad_q;
  logic [DATA_WIDTH-1:0]    wd_q;
  logic                     err_q;
  logic [31:0]              instret_q;

  logic                     transfer;
  logic                     is_load;
  logic [DATA_WIDTH-1:0]    alu_sel_d;
  logic [DATA_WIDTH-1:0]    load_data_d;
  logic                     load_misal_d;
  logic                     cap_misal_d;
  logic [DATA_WIDTH-1:0]    cap_unused_d;

  assign in_ready  = rst_n && (state_q == WB_IDLE);
  assign transfer  = in_valid && in_ready;
  assign is_load   = (in_result_src == RES_MEM);
  assign alu_sel_d = select_result(in_result_src, in_alu_result, in_pc_plus4);

  // Alignment of the incoming load is judged when it is captured.
  load_extend u_cap_check (
    .word_i       (in_alu_result),
    .addr_i       (in_alu_result[1:0]),
    .funct3_i     (in_funct3),
    .data_o       (cap_unused_d),
    .misaligned_o (cap_misal_d)
  );

  load_extend u_load_extend (
    .word_i       (mem_rdata),
    .addr_i       (addr_q),
    .funct3_i     (funct3_q),
    .data_o       (load_data_d),
    .misaligned_o (load_misal_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WB_IDLE;
      rd_q        <= '0;
      funct3_q    <= '0;
      addr_q      <= '0;
      reg_write_q <= 1'b0;
      misal_q     <= 1'b0;
      we_q        <= 1'b0;
      ad_q        <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      instret_q   <= '0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        WB_IDLE: begin
          if (transfer && !flush) begin
            if (is_load) begin
              rd_q        <= in_rd;
              funct3_q    <= in_funct3;
              addr_q      <= in_alu_result[1:0];
              reg_write_q <= in_reg_write;
              misal_q     <= cap_misal_d;
              state_q     <= WB_WAIT_MEM;
            end else begin
              we_q      <= in_reg_write && (in_rd != '0);
              ad_q      <= in_rd;
              wd_q      <= alu_sel_d;
              instret_q <= instret_q + 32'd1;
            end
          end
        end
        WB_WAIT_MEM: begin
          if (mem_rvalid) begin
            state_q <= WB_IDLE;
            if (!flush) begin
              if (misal_q) begin
                err_q <= 1'b1;
              end else begin
                we_q      <= reg_write_q && (rd_q != '0);
                ad_q      <= rd_q;
                wd_q      <= load_data_d;
                instret_q <= instret_q + 32'd1;
              end
            end
          end else if (flush) begin
            state_q <= WB_DRAIN;
          end
        end
        WB_DRAIN: begin
          if (mem_rvalid) state_q <= WB_IDLE;
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign WE3          = we_q;
  assign AD3          = ad_q;
  assign WD3          = wd_q;
  assign misalign_err = err_q;
  assign instret      = instret_q;

  // The capture-side extender only contributes its alignment flag.
  logic unused_ok;
  assign unused_ok = ^{cap_unused_d, load_misal_d};

endmodule
